uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_sync2.sv | 31 +++
 rtl/uart_rx.sv | 182 ++++++++++++++++++
 tb/tb_uart_rx.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: the FSM state enum (also used by the transmitter),
// counter/data widths, the received-frame payload and small helper functions.
package uart_pkg;

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    // Result of one received frame, presented together on rx_valid_o.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              parity_err;
        logic              frame_err;
    } uart_rx_result_t;

    // System clocks per serial bit (integer division).
    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

    // 2-of-3 majority vote.
    function automatic logic majority3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input.
// Ports:
//   clk     - system clock
//   rst     - asynchronous active-high reset, both flops load RST_VAL
//   i_async - asynchronous input
//   o_sync  - synchronized output
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8-P-1 frame (start, 8 data LSB first, parity, stop).
// Build option: define UART_RX_MAJORITY_EN for 2-of-3 majority sampling
// around each bit centre; otherwise a single centre sample is used. Both
// builds have identical latency and interface.
// Ports:
//   clk          - system clock, rising edge
//   rst          - asynchronous active-high reset
//   rx_line_i    - serial input, asynchronous, idles high
//   rx_data_o    - last received byte, held until the next rx_valid_o
//   rx_valid_o   - one-cycle pulse when a frame completes
//   parity_err_o - parity mismatch, qualified by rx_valid_o
//   frame_err_o  - stop bit sampled low, qualified by rx_valid_o
//   rx_busy_o    - high from start detect until the stop bit is sampled
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_line_i,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    output logic              parity_err_o,
    output logic              frame_err_o,
    output logic              rx_busy_o
);

    localparam int unsigned     CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int unsigned     HALF_BIT     = CLKS_PER_BIT / 2;
    localparam logic [CNT_W-1:0] BIT_LAST    = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST   = CNT_W'(HALF_BIT - 1);
    localparam logic            PAR_ODD      = (PARITY_ODD != 0);

    logic w_line;
    logic w_sample;
    logic w_par_exp;

    uart_sync2 #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (rx_line_i),
        .o_sync  (w_line)
    );

    // The decision cycle is one cycle after the nominal bit centre, so the
    // sample window (centre-1, centre, centre+1) is complete in both builds.
`ifdef UART_RX_MAJORITY_EN
    logic [1:0] r_hist;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist <= 2'b11;
        end else begin
            r_hist <= {r_hist[0], w_line};
        end
    end

    assign w_sample = majority3({r_hist, w_line});
`else
    logic r_hist;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist <= 1'b1;
        end else begin
            r_hist <= w_line;
        end
    end

    assign w_sample = r_hist;
`endif

    uart_state_e       r_state;
    logic [CNT_W-1:0]  r_count;
    logic [2:0]        r_bit_idx;
    logic [DATA_W-1:0] r_shift;
    logic              r_parity_err;
    logic              r_armed;
    uart_rx_result_t   r_result;
    logic              r_valid;
    logic              r_busy;

    assign w_par_exp = PAR_ODD ? ~(^r_shift) : ^r_shift;

    // Receive FSM; r_armed blocks a new start detect after a break until
    // the line has been seen high again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_parity_err <= 1'b0;
            r_armed      <= 1'b1;
            r_result     <= '0;
            r_valid      <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_count   <= '0;
                    r_bit_idx <= '0;
                    if (w_line) begin
                        r_armed <= 1'b1;
                    end else if (r_armed) begin
                        r_state <= START;
                        r_busy  <= 1'b1;
                    end
                end
                START: begin
                    if (r_count == HALF_LAST) begin
                        r_count <= '0;
                        if (!w_sample) begin
                            r_state <= DATA;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (r_count == BIT_LAST) begin
                        r_count            <= '0;
                        r_shift[r_bit_idx] <= w_sample;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= PARITY;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                PARITY: begin
                    if (r_count == BIT_LAST) begin
                        r_count      <= '0;
                        r_parity_err <= (w_sample != w_par_exp);
                        r_state      <= STOP;
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (r_count == BIT_LAST) begin
                        r_count             <= '0;
                        r_bit_idx           <= '0;
                        r_result.data       <= r_shift;
                        r_result.parity_err <= r_parity_err;
                        r_result.frame_err  <= ~w_sample;
                        r_valid             <= 1'b1;
                        r_busy              <= 1'b0;
                        r_state             <= IDLE;
                        if (!w_sample) begin
                            r_armed <= 1'b0;
                        end
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data_o    = r_result.data;
    assign parity_err_o = r_result.parity_err;
    assign frame_err_o  = r_result.frame_err;
    assign rx_valid_o   = r_valid;
    assign rx_busy_o    = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: an even-parity and an odd-parity receiver share one
// serial line; expected frames are queued per receiver and a monitor
// compares them whenever rx_valid_o pulses.
module tb_uart_rx;

    localparam int unsigned CPB = 434;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_line;
    logic [7:0] d_e, d_o;
    logic       v_e, v_o, pe_e, pe_o, fe_e, fe_o, b_e, b_o;

    always #10 clk = ~clk;

    uart_rx #(.CLK_FREQ(50000000), .BAUD_RATE(115200), .PARITY_ODD(0)) dut_even (
        .clk(clk), .rst(rst), .rx_line_i(rx_line), .rx_data_o(d_e),
        .rx_valid_o(v_e), .parity_err_o(pe_e), .frame_err_o(fe_e), .rx_busy_o(b_e)
    );

    uart_rx #(.CLK_FREQ(50000000), .BAUD_RATE(115200), .PARITY_ODD(1)) dut_odd (
        .clk(clk), .rst(rst), .rx_line_i(rx_line), .rx_data_o(d_o),
        .rx_valid_o(v_o), .parity_err_o(pe_o), .frame_err_o(fe_o), .rx_busy_o(b_o)
    );

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc   = 0;
    logic [9:0] q_e[$];
    logic [9:0] q_o[$];
    int         v_cyc[$];
    logic [9:0] exp_e, exp_o;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: packed compare of {data, parity_err, frame_err}.
    always @(negedge clk) begin
        if (v_e === 1'b1) begin
            v_cyc.push_back(cyc);
            if (q_e.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL even_unexpected_valid: got data %02h, none expected", d_e);
            end else begin
                exp_e = q_e.pop_front();
                check("even_frame", 32'({d_e, pe_e, fe_e}), 32'(exp_e));
            end
        end
        if (v_o === 1'b1) begin
            if (q_o.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL odd_unexpected_valid: got data %02h, none expected", d_o);
            end else begin
                exp_o = q_o.pop_front();
                check("odd_frame", 32'({d_o, pe_o, fe_o}), 32'(exp_o));
            end
        end
    end

    task automatic hold(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] d, input logic pe_even, input logic pe_odd,
                            input logic fe);
        q_e.push_back({d, pe_even, fe});
        q_o.push_back({d, pe_odd, fe});
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        logic [10:0] bits;
        bits = {s, p, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            rx_line = bits[i];
            hold(CPB);
        end
    endtask

    int  fall_k;
    bit  saw_busy;
    int  n0;

    initial begin
        rst     = 1'b1;
        rx_line = 1'b1;
        hold(5);
        check("rst_data",   32'(d_e),  32'h0);
        check("rst_valid",  32'(v_e),  32'h0);
        check("rst_perr",   32'(pe_e), 32'h0);
        check("rst_ferr",   32'(fe_e), 32'h0);
        check("rst_busy",   32'(b_e),  32'h0);
        rst = 1'b0;
        hold(20);

        // Clean frame; odd receiver sees a parity error.
        push_exp(8'hA5, 1'b0, 1'b1, 1'b0);
        send_frame(8'hA5, 1'b0, 1'b1);
        push_exp(8'h3C, 1'b0, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b1);
        hold(CPB);

        // 100-cycle low glitch must be rejected at the half-bit check.
        saw_busy = 1'b0;
        fall_k   = 0;
        rx_line  = 1'b0;
        for (int k = 1; k <= 400; k++) begin
            if (k == 100) rx_line = 1'b1;
            hold(1);
            if (b_e === 1'b1) saw_busy = 1'b1;
            else if (saw_busy && fall_k == 0) fall_k = k;
        end
        check("glitch_busy_seen", 32'(saw_busy), 32'h1);
        check("glitch_busy_fall_window", 32'(fall_k >= 212 && fall_k <= 228), 32'h1);
        hold(CPB);

        // Stop bit low followed by a break, then a clean frame.
        push_exp(8'h55, 1'b0, 1'b1, 1'b1);
        send_frame(8'h55, 1'b0, 1'b0);
        hold(2 * CPB);
        rx_line = 1'b1;
        hold(2 * CPB);
        push_exp(8'h0F, 1'b0, 1'b1, 1'b0);
        send_frame(8'h0F, 1'b0, 1'b1);
        hold(CPB);

        // Back-to-back frames with no idle gap.
        n0 = v_cyc.size();
        push_exp(8'h01, 1'b0, 1'b1, 1'b0);
        send_frame(8'h01, 1'b1, 1'b1);
        push_exp(8'hFE, 1'b0, 1'b1, 1'b0);
        send_frame(8'hFE, 1'b1, 1'b1);
        hold(CPB);
        check("b2b_valid_count", 32'(v_cyc.size() - n0), 32'd2);
        if (v_cyc.size() >= n0 + 2)
            check("b2b_spacing", 32'(v_cyc[n0 + 1] - v_cyc[n0]), 32'd4774);

        // Reset during data bit 3 of 0xFF discards the partial frame.
        rx_line = 1'b0;
        hold(CPB);
        for (int i = 0; i < 3; i++) begin
            rx_line = 1'b1;
            hold(CPB);
        end
        hold(200);
        rst     = 1'b1;
        rx_line = 1'b1;
        hold(5);
        check("midrst_busy", 32'(b_e), 32'h0);
        check("midrst_data", 32'(d_e), 32'h0);
        check("midrst_odd_data", 32'(d_o), 32'h0);
        rst = 1'b0;
        hold(2 * CPB);
        push_exp(8'h12, 1'b1, 1'b0, 1'b0);
        send_frame(8'h12, 1'b1, 1'b1);
        hold(2 * CPB);

        check("even_queue_drained", 32'(q_e.size()), 32'h0);
        check("odd_queue_drained",  32'(q_o.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
